// File: rtl/pwm_pkg.sv
// pwm_pkg: default PWM width/dead-time and period helpers shared by the PWM block.
package pwm_pkg;
    localparam int WIDTH_DEF  = 4;
    localparam int DEAD_DEF   = 1;
    localparam int PERIOD_DEF = 1 << WIDTH_DEF;

    function automatic int period_of(input int w);
        return 1 << w;
    endfunction
endpackage

// File: rtl/pwm_counter.sv
// pwm_counter: free-running period counter with a duty shadow register reloaded at each wrap.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] duty_sh,
    output logic             wrap
);
    // Reset parks the counter at all ones so the first enabled edge starts a period.
    assign wrap = CE && (cnt == '1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt     <= '1;
            duty_sh <= '0;
        end else if (CE) begin
            cnt <= cnt + 1'b1;
            if (wrap) duty_sh <= D;
        end
    end
endmodule

// File: rtl/pwm_verilog.sv
// pwm_verilog: registered PWM generator; define PWM_COMPLEMENT_EN to add the dead-time
// complementary output PWM_N.
module pwm_verilog
    import pwm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEAD  = DEAD_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    output logic             PWM
`ifdef PWM_COMPLEMENT_EN
    ,
    output logic             PWM_N
`endif
);
    logic [WIDTH-1:0] cnt, duty_sh, cnt_nx, duty_nx;
    logic             wrap;

    if (DEAD < 0 || DEAD >= (1 << WIDTH)) begin : g_bad_dead
        $error("pwm_verilog: DEAD out of range");
    end

    pwm_counter #(.WIDTH(WIDTH)) u_counter (
        .CLK    (CLK),
        .RST    (RST),
        .CE     (CE),
        .D      (D),
        .cnt    (cnt),
        .duty_sh(duty_sh),
        .wrap   (wrap)
    );

    // Compare on post-edge values so PWM lines up with the counter it describes.
    assign cnt_nx  = cnt + 1'b1;
    assign duty_nx = wrap ? D : duty_sh;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) PWM <= 1'b0;
        else if (CE) PWM <= cnt_nx < duty_nx;
    end

`ifdef PWM_COMPLEMENT_EN
    localparam int PERIOD = period_of(WIDTH);
    logic pwm_n_nx;

    // Low side waits DEAD cycles after PWM falls and drops DEAD cycles before the next period.
    assign pwm_n_nx = (int'(cnt_nx) >= int'(duty_nx) + DEAD) && (int'(cnt_nx) < PERIOD - DEAD);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) PWM_N <= 1'b0;
        else if (CE) PWM_N <= pwm_n_nx;
    end
`endif
endmodule

// File: tb/tb_pwm_verilog.sv
// tb_pwm_verilog: table-driven, scoreboarded check of pwm_verilog (optionally PWM_COMPLEMENT_EN).
module tb_pwm_verilog;
    localparam int W = 4;
    localparam int P = 1 << W;

    typedef struct {
        logic [W-1:0] d;
        bit           toggle;
        int           ticks;
        int           exp_high;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ce  = 1'b0;
    logic [W-1:0] d   = '0;
    logic         pwm;
`ifdef PWM_COMPLEMENT_EN
    logic         pwm_n;
`endif

    int           checks = 0;
    int           fails  = 0;
    bit           exp_q[$];
    int           n  = 0;
    logic [W-1:0] dm = '0;
    bit           em = 1'b0;

    always #10 clk = ~clk;

    pwm_verilog #(.WIDTH(W), .DEAD(1)) dut (
        .CLK(clk),
        .RST(rst),
        .CE (ce),
        .D  (d),
        .PWM(pwm)
`ifdef PWM_COMPLEMENT_EN
        ,
        .PWM_N(pwm_n)
`endif
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected PWM from the period definition: enabled edge n lands at phase n mod 2^W,
    // duty latched from D at phase 0, high while phase < duty.
    task automatic tick(input bit en);
        int ph;
        ce = en;
        @(posedge clk);
        if (en) begin
            ph = n % P;
            if (ph == 0) dm = d;
            em = ph < int'(dm);
            n++;
        end
        exp_q.push_back(em);
        @(negedge clk);
    endtask

    task automatic run(input int ticks, input bit toggle, output int high);
        high = 0;
        for (int i = 0; i < ticks; i++) begin
            tick(toggle ? (i % 2 == 0) : 1'b1);
            high += int'(pwm);
        end
    endtask

    task automatic do_reset(input logic [W-1:0] dv);
        #2 rst = 1'b1;
        ce = 1'b1;
        d  = dv;
        #1 check("reset_state", pwm, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
        em  = 1'b0;
        dm  = '0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check("pwm_cycle", pwm, exp_q.pop_front());
`ifdef PWM_COMPLEMENT_EN
        if (!rst) check("no_overlap", pwm & pwm_n, 1'b0);
`endif
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[7];
        int   hi;
        vecs[0] = '{d: 4'd9,  toggle: 1'b0, ticks: 32, exp_high: 18};
        vecs[1] = '{d: 4'd0,  toggle: 1'b0, ticks: 32, exp_high: 0};
        vecs[2] = '{d: 4'd15, toggle: 1'b0, ticks: 32, exp_high: 30};
        vecs[3] = '{d: 4'd3,  toggle: 1'b0, ticks: 32, exp_high: 6};
        vecs[4] = '{d: 4'd1,  toggle: 1'b0, ticks: 32, exp_high: 2};
        vecs[5] = '{d: 4'd9,  toggle: 1'b1, ticks: 64, exp_high: 36};
        vecs[6] = '{d: 4'd8,  toggle: 1'b1, ticks: 64, exp_high: 32};

        @(negedge clk);
        foreach (vecs[i]) begin
            do_reset(vecs[i].d);
            run(vecs[i].ticks, vecs[i].toggle, hi);
            check_int($sformatf("high_count_d%0d_t%0d", vecs[i].d, vecs[i].toggle), hi, vecs[i].exp_high);
        end

        // Duty change mid-period only takes effect at the next period start.
        do_reset(4'd9);
        run(5, 1'b0, hi);
        d = 4'd3;
        run(11, 1'b0, hi);
        check_int("dchg_rest_of_period", hi, 4);
        run(16, 1'b0, hi);
        check_int("dchg_next_period", hi, 3);

        // Asynchronous reset mid-high-phase, then restart with the current D.
        do_reset(4'd9);
        run(6, 1'b0, hi);
        check("pre_reset_high", pwm, 1'b1);
        #2 rst = 1'b1;
        #1 check("async_reset_clear", pwm, 1'b0);
        d = 4'd5;
        @(negedge clk);
        check("reset_hold", pwm, 1'b0);
        rst = 1'b0;
        n   = 0;
        em  = 1'b0;
        dm  = '0;
        run(1, 1'b0, hi);
        check("restart_first_edge", pwm, 1'b1);
        run(15, 1'b0, hi);
        check_int("restart_period_high", hi + 1, 5);

        @(negedge clk);
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/pwm_verilog.md
PWM_VERILOG -- requirements
Module: pwm_verilog

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the duty-input and counter width; the period is 2^WIDTH enabled cycles.
REQ-002 Parameter DEAD, default 1, SHALL set the dead-time in enabled cycles; it is used only when PWM_COMPLEMENT_EN is defined.
REQ-003 Port CLK, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port RST, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-005 Port CE, input, 1 bit, SHALL be the count enable; state SHALL advance only on edges where CE=1.
REQ-006 Port D, input, WIDTH bits, SHALL be the unsigned requested duty in enabled cycles per period.
REQ-007 Port PWM, output, 1 bit, SHALL be the registered PWM output.
REQ-008 Port PWM_N, output, 1 bit, SHALL exist only under PWM_COMPLEMENT_EN and carry the complementary output with dead-time.

Function
REQ-009 Internal counter cnt (WIDTH bits) SHALL increment by 1 on every CE=1 edge and wrap from 2^WIDTH-1 to 0.
REQ-010 Shadow register duty_sh SHALL load D on the CE=1 edge where cnt wraps to 0, and at no other time, so that D changes take effect only at the next period start.
REQ-011 PWM SHALL be a flop updated on CE=1 edges to (cnt_new < duty_sh_new), evaluated on post-edge values; it SHALL be glitch-free.
REQ-012 With CE=0, cnt, duty_sh and PWM SHALL hold their values.
REQ-013 D=0 SHALL give PWM constantly 0; D=2^WIDTH-1 SHALL give PWM high for 2^WIDTH-1 cycles and low for 1 cycle per period; 100% duty is not supported.
REQ-014 For general D=k, each period SHALL be k enabled cycles high followed by 2^WIDTH-k enabled cycles low, with the high phase starting at cnt=0.
REQ-015 Comparison SHALL be unsigned at WIDTH bits; no width extension of D is permitted.

Reset
REQ-016 RST=1 SHALL immediately force cnt to all ones, duty_sh=0, PWM=0 (and PWM_N=0), independent of CLK and CE.
REQ-017 The first CE=1 edge after RST deasserts SHALL wrap cnt to 0, load D, and start the first period with no idle period.
REQ-018 Reset asserted mid-period SHALL abort the period; the restart SHALL follow REQ-017.

Configuration
REQ-019 Macro PWM_COMPLEMENT_EN defined: PWM_N SHALL be present, high exactly when PWM is low, except that each rising edge of PWM and PWM_N is delayed by DEAD enabled cycles after the other signal falls; the two SHALL never be high simultaneously.
REQ-020 Macro PWM_COMPLEMENT_EN undefined: PWM_N and its dead-time logic SHALL be absent, and PWM behaviour SHALL be unchanged.

Structure
REQ-021 Package pwm_pkg SHALL hold the default WIDTH and DEAD constants and a localparam computing the period (2^WIDTH).
REQ-022 The counter and shadow-load logic SHALL be a sub-module pwm_counter (outputs cnt and the wrap strobe); compare, output flop and dead-time logic SHALL stay in pwm_verilog.

Verification
REQ-023 Clock 20 ns, CE=1, D=9 after reset -> PWM high 9 clocks, low 7 clocks, period 320 ns, repeating.
REQ-024 D=0 -> PWM always 0; D=15 -> PWM high 15 clocks, low 1 clock per 16.
REQ-025 CE toggling 1/0 each clock, D=9 -> PWM high 18 clocks, low 14 clocks; state holds on CE=0 edges.
REQ-026 D changes 9->3 at cnt=4 -> current period completes with 9 high; next period has 3 high.
REQ-027 RST pulsed at cnt=5 while PWM=1 -> PWM=0 immediately without a clock edge; the first CE edge after release starts a new period using current D.
REQ-028 PWM_COMPLEMENT_EN defined, DEAD=1, D=9 -> PWM_N rises 1 cycle after PWM falls and falls with PWM's rise-minus-1 timing; PWM&PWM_N is never 1.
